// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: shared types and opcode constants for the RV32I instruction loader.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_J = 3'd4,
        FMT_U = 3'd5
    } fmt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    // True when v is representable as an n-bit two's-complement value.
    function automatic logic fits(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = $signed(v) >>> (n - 1);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packing with immediate range checking.
module instr_pack
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  op_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        bad_o
);

    logic shift;
    assign shift = (op_i == OP_I) && (funct3_i == 3'b001 || funct3_i == 3'b101);

    always_comb begin
        word_o = '0;
        bad_o  = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            FMT_I: begin
                word_o = shift ? {1'b0, funct7b5_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, op_i}
                               : {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                bad_o  = shift ? |imm_i[31:5] : !fits(imm_i, 12);
            end
            FMT_S: begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                bad_o  = !fits(imm_i, 12);
            end
            FMT_B: begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], op_i};
                bad_o  = !fits(imm_i, 13) || imm_i[0];
            end
            FMT_J: begin
                word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                bad_o  = !fits(imm_i, 21) || imm_i[0];
            end
            FMT_U: begin
                word_o = {imm_i[31:12], rd_i, op_i};
                bad_o  = |imm_i[11:0];
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts field-level commands, encodes them and writes the words to
// consecutive instruction-memory locations starting at base_addr.
module instr_loader
    import riscv_enc_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [2:0]    fmt_i,
    input  logic [6:0]    op_i,
    input  logic [2:0]    funct3_i,
    input  logic          funct7b5_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [31:0]   imm_i,
    input  logic          last_i,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    output logic [AW:0]   count_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [AW:0]   CMAX  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PLAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   wdata_q, wdata_d, word;
    logic          err_q, err_d, last_q, last_d, bad;

    instr_pack u_pack (
        .fmt_i      (fmt_i),
        .op_i       (op_i),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .rd_i       (rd_i),
        .rs1_i      (rs1_i),
        .rs2_i      (rs2_i),
        .imm_i      (imm_i),
        .word_o     (word),
        .bad_o      (bad)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        last_d  = last_q;
        if (start_i) begin
            state_d = S_LOAD;
            ptr_d   = base_addr_i;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_LOAD: if (cmd_valid_i) begin
                    if (bad) begin
                        err_d   = 1'b1;
                        state_d = last_i ? S_DONE : S_LOAD;
                    end else begin
                        addr_d  = ptr_q;
                        wdata_d = word;
                        last_d  = last_i;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    cnt_d   = (cnt_q == CMAX) ? cnt_q : cnt_q + (AW+1)'(1);
                    ptr_d   = (ptr_q == PLAST) ? ptr_q : ptr_q + AW'(1);
                    // Writing the top word ends the load; there is no wrap to address 0.
                    err_d   = err_q || (!last_q && ptr_q == PLAST);
                    state_d = (last_q || ptr_q == PLAST) ? S_DONE : S_LOAD;
                end
                default: ;
            endcase
        end
    end

    // A start during WRITE drops the pending word before it reaches memory.
    always_comb begin
        cmd_ready_o = (state_q == S_LOAD) && !start_i;
        mem_we_o    = (state_q == S_WRITE) && !start_i;
        busy_o      = (state_q == S_LOAD) || (state_q == S_WRITE);
        done_o      = (state_q == S_DONE);
        err_o       = err_q;
        count_o     = cnt_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
    end

endmodule
